hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline (F/D/E/M/W).
- Internally tracks the register-destination and source state of the E, M and W stages.
- Produces the operand-select codes consumed by the E-stage forwarding muxes (ForwardAE/ForwardBE) and the D-stage branch-compare muxes.
- Produces the StallF/StallD/FlushE controls for load-use and branch hazards.

Parameters:
- REG_AW, 5, register-address width.
- FWD_RF, 2'd0, select code: register-file operand.
- FWD_WB, 2'd1, select code: ResultW.
- FWD_MEM, 2'd2, select code: ALUOutM.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RsD  in  REG_AW  D-stage source register A.
- RtD  in  REG_AW  D-stage source register B.
- WriteRegD  in  REG_AW  D-stage destination register (already muxed rd/rt/31).
- RegWriteD  in  1  D-stage instruction writes a register.
- MemtoRegD  in  1  D-stage instruction is a load.
- BranchD  in  1  D-stage instruction is a branch compared in D.
- ForwardAE  out  2  E-stage operand A select.
- ForwardBE  out  2  E-stage operand B select.
- ForwardAD  out  1  D-stage branch operand A takes ALUOutM.
- ForwardBD  out  1  D-stage branch operand B takes ALUOutM.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- FlushE  out  1  clear ID/EX register (insert bubble).
- stall_cnt  out  16  saturating count of stall cycles since reset.

Behaviour:
- Internal stage registers, all cleared to 0 by rst_n low, independent of clk:
  - E stage: RsE, RtE, WriteRegE, RegWriteE, MemtoRegE.
  - M stage: WriteRegM, RegWriteM, MemtoRegM.
  - W stage: WriteRegW, RegWriteW.
- Each rising clk:
  - M takes E, and W takes M, unconditionally.
  - E takes the D inputs when FlushE=0.
  - When FlushE=1, E is loaded with zeros (bubble: RegWriteE=0, MemtoRegE=0, regs=0).
- ForwardAE, combinational from registered state; priority M over W:
  - FWD_MEM if RsE!=0 && RegWriteM && WriteRegM==RsE.
  - else FWD_WB if RsE!=0 && RegWriteW && WriteRegW==RsE.
  - else FWD_RF.
- ForwardBE: identical rule using RtE. Code 2'd3 is never driven.
- ForwardAD = RsD!=0 && RegWriteM && WriteRegM==RsD. ForwardBD likewise with RtD.
  - No W-stage branch forward: the register file writes on the first half-cycle.
- lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- branchstall = BranchD && one of:
  - RegWriteE && (WriteRegE==RsD || WriteRegE==RtD), or
  - MemtoRegM && (WriteRegM==RsD || WriteRegM==RtD).
- StallF = StallD = FlushE = lwstall | branchstall. Combinational, so 0-cycle latency from inputs and state.
- A load immediately followed by a dependent branch stalls 2 cycles: first branchstall+lwstall, then branchstall via MemtoRegM.
- Register $0 as a destination never triggers a stall when RegWriteE=0. A bubble in E (all-zero) never causes a stall or forward.
- stall_cnt increments on each clk edge with StallD=1 and saturates at 16'hFFFF. Reset value 0.
- All outputs are 0 during reset, since they derive from zeroed state. The exception is StallF/StallD/FlushE, which may assert from D inputs alone only if BranchD/Rs match; E/M are zero, so with MemtoRegE=0, RegWriteE=0 they are 0.
- Reset mid-stall clears the pipeline state; the stall deasserts in the same cycle.

Decomposition:
- Shared package holds:
  - Forward select constants FWD_RF/FWD_WB/FWD_MEM, so the mux modules and this block agree.
  - REG_AW.
  - A stage-tag struct {wreg, regwrite, memtoreg}.
- One natural sub-module: fwd_compare, instantiated twice (A/B). It takes a source reg plus the M/W tags and returns the 2-bit select.

Test Plan:
- add $8 then add $9,$8,$10 in consecutive cycles -> in 2nd instruction's E cycle ForwardAE=2'd2, ForwardBE=2'd0, no stall.
- add $8; nop; sub $9,$10,$8 -> ForwardBE=2'd1 in sub's E cycle. Same plus an add $8 in between -> ForwardBE=2'd2 (M priority).
- lw $8 then add $9,$8,$8 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Next cycle ForwardAE=ForwardBE=2'd1. stall_cnt=1.
- lw $8 then beq $8,$0 -> 2 stall cycles, then ForwardAD=0 (value from RF). add $8 then beq $8,$9 -> 1 stall, then ForwardAD=1.
- Writes to $0 followed by readers of $0 -> all forwards 2'd0, no stall.
- Assert rst_n=0 during a load-use stall -> all stage regs, stall outputs and stall_cnt read 0 immediately. Release -> normal operation resumes.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_forward_ctrl_pkg
// Brief   : Shared constants, stage-tag type and match helper for the
//           hazard/forwarding controller and the datapath forwarding muxes.
// Revision: 1.0  initial release
// ============================================================================
package hazard_forward_ctrl_pkg;

  localparam int REG_AW = 5;

  // Operand-select codes understood by the E-stage forwarding muxes
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  // Destination summary carried by each pipeline stage
  typedef struct packed {
    logic [REG_AW-1:0] wreg;
    logic              regwrite;
    logic              memtoreg;
  } stage_tag_t;

  // True when a stage will write the (non-$0) source register
  function automatic logic tag_hit(input stage_tag_t tag, input logic [REG_AW-1:0] src);
    return (src != '0) && tag.regwrite && (tag.wreg == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_forward_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_forward_ctrl_if
// Brief   : D-stage decode inputs and hazard/forward control outputs.
// Revision: 1.0  initial release
// ============================================================================
interface hazard_forward_ctrl_if;
  import hazard_forward_ctrl_pkg::*;

  logic [REG_AW-1:0] RsD;
  logic [REG_AW-1:0] RtD;
  logic [REG_AW-1:0] WriteRegD;
  logic              RegWriteD;
  logic              MemtoRegD;
  logic              BranchD;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              ForwardAD;
  logic              ForwardBD;
  logic              StallF;
  logic              StallD;
  logic              FlushE;
  logic [15:0]       stall_cnt;

  // Pipeline datapath side
  modport master (
    output RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, stall_cnt
  );

  // Hazard controller side
  modport slave (
    input  RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/hazard_forward_ctrl_fwd_compare.sv
`default_nettype none
// ============================================================================
// Module  : hazard_forward_ctrl_fwd_compare
// Brief   : E-stage operand select for one source register; M wins over W.
// Revision: 1.0  initial release
// ============================================================================
module hazard_forward_ctrl_fwd_compare
  import hazard_forward_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  stage_tag_t        m_tag_i,
  input  stage_tag_t        w_tag_i,
  output logic [1:0]        sel_o
);

  // Load flag is irrelevant to forwarding; sink it explicitly
  logic unused_memtoreg;
  assign unused_memtoreg = m_tag_i.memtoreg ^ w_tag_i.memtoreg;

  // Youngest producer (M) has priority over the older one (W)
  always_comb begin
    sel_o = FWD_RF;
    if (tag_hit(m_tag_i, src_i)) begin
      sel_o = FWD_MEM;
    end else if (tag_hit(w_tag_i, src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_forward_ctrl
// Brief   : Tracks E/M/W destination state and produces forwarding selects
//           plus load-use / branch stall and flush controls.
// Revision: 1.0  initial release
// ============================================================================
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_forward_ctrl_if.slave bus
);

  stage_tag_t        e_tag_q, e_tag_d;
  stage_tag_t        m_tag_q;
  stage_tag_t        w_tag_q;
  logic [REG_AW-1:0] rs_e_q, rs_e_d;
  logic [REG_AW-1:0] rt_e_q, rt_e_d;
  logic [15:0]       stall_cnt_q;

  logic lwstall;
  logic branchstall;
  logic stall;

  // A stall turns the instruction entering E into an all-zero bubble
  always_comb begin
    e_tag_d = '{wreg: bus.WriteRegD, regwrite: bus.RegWriteD, memtoreg: bus.MemtoRegD};
    rs_e_d  = bus.RsD;
    rt_e_d  = bus.RtD;
    if (stall) begin
      e_tag_d = '0;
      rs_e_d  = '0;
      rt_e_d  = '0;
    end
  end

  // Advance the stage tracking registers every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_tag_q <= '0;
      rs_e_q  <= '0;
      rt_e_q  <= '0;
      m_tag_q <= '0;
      w_tag_q <= '0;
    end else begin
      e_tag_q <= e_tag_d;
      rs_e_q  <= rs_e_d;
      rt_e_q  <= rt_e_d;
      m_tag_q <= e_tag_q;
      w_tag_q <= m_tag_q;
    end
  end

  // Load in E whose target is read by the instruction in D
  assign lwstall = e_tag_q.memtoreg && ((rt_e_q == bus.RsD) || (rt_e_q == bus.RtD));

  // D-stage branch compare needs a value not yet available in M
  assign branchstall = bus.BranchD &&
      ((e_tag_q.regwrite && ((e_tag_q.wreg == bus.RsD) || (e_tag_q.wreg == bus.RtD))) ||
       (m_tag_q.memtoreg && ((m_tag_q.wreg == bus.RsD) || (m_tag_q.wreg == bus.RtD))));

  assign stall = lwstall | branchstall;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  hazard_forward_ctrl_fwd_compare u_fwd_a (
    .src_i   (rs_e_q),
    .m_tag_i (m_tag_q),
    .w_tag_i (w_tag_q),
    .sel_o   (bus.ForwardAE)
  );

  hazard_forward_ctrl_fwd_compare u_fwd_b (
    .src_i   (rt_e_q),
    .m_tag_i (m_tag_q),
    .w_tag_i (w_tag_q),
    .sel_o   (bus.ForwardBE)
  );

  // Branch operands only forward from M; W is covered by the RF write-first
  assign bus.ForwardAD = tag_hit(m_tag_q, bus.RsD);
  assign bus.ForwardBD = tag_hit(m_tag_q, bus.RtD);

  assign bus.StallF    = stall;
  assign bus.StallD    = stall;
  assign bus.FlushE    = stall;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_forward_ctrl
// Brief   : Directed instruction sequences with hand-computed expectations,
//           checked by a scoreboard monitor on the falling clock edge.
// Revision: 1.0  initial release
// ============================================================================
module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
    logic       rw;
    logic       mtr;
    logic       br;
  } ins_t;

  typedef struct {
    string       nm;
    logic [1:0]  ae;
    logic [1:0]  be;
    logic        ad;
    logic        bd;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  //                                rs     rt     wr     rw    mtr   br
  localparam ins_t NOP     = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
  localparam ins_t ADD8    = '{5'd1,  5'd2,  5'd8,  1'b1, 1'b0, 1'b0};
  localparam ins_t ADD8B   = '{5'd3,  5'd4,  5'd8,  1'b1, 1'b0, 1'b0};
  localparam ins_t ADD9_8A = '{5'd8,  5'd10, 5'd9,  1'b1, 1'b0, 1'b0};
  localparam ins_t SUB9    = '{5'd10, 5'd8,  5'd9,  1'b1, 1'b0, 1'b0};
  localparam ins_t LW8     = '{5'd29, 5'd8,  5'd8,  1'b1, 1'b1, 1'b0};
  localparam ins_t ADD9_88 = '{5'd8,  5'd8,  5'd9,  1'b1, 1'b0, 1'b0};
  localparam ins_t BEQ80   = '{5'd8,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1};
  localparam ins_t BEQ89   = '{5'd8,  5'd9,  5'd0,  1'b0, 1'b0, 1'b1};
  localparam ins_t ADD0    = '{5'd1,  5'd2,  5'd0,  1'b1, 1'b0, 1'b0};
  localparam ins_t ADD3_00 = '{5'd0,  5'd0,  5'd3,  1'b1, 1'b0, 1'b0};
  localparam ins_t ADD5_00 = '{5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0};

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  hazard_forward_ctrl_if hz_if ();

  hazard_forward_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hz_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
    end
  endtask

  // Drive one D-stage instruction just after the edge and queue its expectation
  task automatic cyc(input string nm, input logic rn, input ins_t ins,
                     input logic [1:0] eae, input logic [1:0] ebe,
                     input logic ead, input logic ebd, input logic est,
                     input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rn;
    hz_if.RsD       = ins.rs;
    hz_if.RtD       = ins.rt;
    hz_if.WriteRegD = ins.wr;
    hz_if.RegWriteD = ins.rw;
    hz_if.MemtoRegD = ins.mtr;
    hz_if.BranchD   = ins.br;
    e.nm = nm; e.ae = eae; e.be = ebe; e.ad = ead; e.bd = ebd; e.st = est; e.cnt = ecnt;
    sb.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "ForwardAE", {14'd0, hz_if.ForwardAE}, {14'd0, e.ae});
        chk(e.nm, "ForwardBE", {14'd0, hz_if.ForwardBE}, {14'd0, e.be});
        chk(e.nm, "ForwardAD", {15'd0, hz_if.ForwardAD}, {15'd0, e.ad});
        chk(e.nm, "ForwardBD", {15'd0, hz_if.ForwardBD}, {15'd0, e.bd});
        chk(e.nm, "StallF",    {15'd0, hz_if.StallF},    {15'd0, e.st});
        chk(e.nm, "StallD",    {15'd0, hz_if.StallD},    {15'd0, e.st});
        chk(e.nm, "FlushE",    {15'd0, hz_if.FlushE},    {15'd0, e.st});
        chk(e.nm, "stall_cnt", hz_if.stall_cnt,          e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    hz_if.RsD = '0; hz_if.RtD = '0; hz_if.WriteRegD = '0;
    hz_if.RegWriteD = 1'b0; hz_if.MemtoRegD = 1'b0; hz_if.BranchD = 1'b0;

    //  name          rn    instr    AE    BE    AD    BD    stall cnt
    cyc("reset0",   1'b0, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("reset1",   1'b0, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    // add $8 ; add $9,$8,$10 -> MEM forward on A
    cyc("t1_c1",    1'b1, ADD8,    2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t1_c2",    1'b1, ADD9_8A, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t1_fwdM",  1'b1, NOP,     2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t1_c4",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t1_c5",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    // add $8 ; nop ; sub $9,$10,$8 -> WB forward on B
    cyc("t2_c1",    1'b1, ADD8,    2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t2_c2",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t2_subD",  1'b1, SUB9,    2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd0);
    cyc("t2_fwdW",  1'b1, NOP,     2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t2_c5",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    // add $8 ; add $8 ; sub -> M has priority over W
    cyc("t3_c1",    1'b1, ADD8,    2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t3_c2",    1'b1, ADD8B,   2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t3_subD",  1'b1, SUB9,    2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd0);
    cyc("t3_prio",  1'b1, NOP,     2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t3_c5",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t3_c6",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    // lw $8 ; add $9,$8,$8 -> one load-use stall
    cyc("t4_lw",    1'b1, LW8,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t4_stall", 1'b1, ADD9_88, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
    cyc("t4_held",  1'b1, ADD9_88, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 16'd1);
    cyc("t4_fwdWW", 1'b1, NOP,     2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc("t4_c5",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc("t4_c6",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    // lw $8 ; beq $8,$0 -> two stall cycles, then operand from RF
    cyc("t5_lw",    1'b1, LW8,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc("t5_st1",   1'b1, BEQ80,   2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd1);
    cyc("t5_st2",   1'b1, BEQ80,   2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd2);
    cyc("t5_go",    1'b1, BEQ80,   2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3);
    cyc("t5_c5",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3);
    cyc("t5_c6",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3);
    cyc("t5_c7",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3);
    // add $8 ; beq $8,$9 -> one stall, then ForwardAD
    cyc("t6_add",   1'b1, ADD8,    2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3);
    cyc("t6_st1",   1'b1, BEQ89,   2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd3);
    cyc("t6_fwdAD", 1'b1, BEQ89,   2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd4);
    cyc("t6_c4",    1'b1, NOP,     2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc("t6_c5",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc("t6_c6",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    // writes to $0 never forward
    cyc("t7_add0",  1'b1, ADD0,    2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc("t7_rd0a",  1'b1, ADD3_00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc("t7_rd0b",  1'b1, ADD5_00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc("t7_c4",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc("t7_c5",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc("t7_c6",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    // reset during a stall, then resume
    cyc("t8_lw",    1'b1, LW8,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc("t8_st1",   1'b1, BEQ80,   2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd4);
    cyc("t8_rst",   1'b0, BEQ80,   2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t8_rsth",  1'b0, BEQ80,   2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t8_lw2",   1'b1, LW8,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t8_st2",   1'b1, ADD9_88, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
    cyc("t8_held",  1'b1, ADD9_88, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 16'd1);
    cyc("t8_fwdWW", 1'b1, NOP,     2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    cyc("t8_c9",    1'b1, NOP,     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
